// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter that shares one i2c_master byte engine among NUM_REQ requesters,
// each posting a 3-byte register write. Optional watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_dev,
    input  logic [8*NUM_REQ-1:0] req_reg,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 nack,
    output logic                 timeout,
    output logic                 m_start,
    output logic                 m_rw,
    output logic [7:0]           m_data,
    input  logic                 m_busy,
    input  logic                 m_ack_error
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] winner_reg;
    logic [1:0]       byte_idx_reg;
    logic             nack_flag_reg;
    logic [6:0]       dev_reg;
    logic [7:0]       reg_addr_reg;
    logic [7:0]       data_reg;

    logic [6:0] dev_arr  [NUM_REQ];
    logic [7:0] reg_arr  [NUM_REQ];
    logic [7:0] data_arr [NUM_REQ];

    logic             win_valid_next;
    logic [IDX_W-1:0] win_idx_next;
    int               cand;
    logic             to_hit;

    if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("i2c_write_arbiter: invalid parameter combination");
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign dev_arr[gi]  = req_dev[gi*7 +: 7];
        assign reg_arr[gi]  = req_reg[gi*8 +: 8];
        assign data_arr[gi] = req_data[gi*8 +: 8];
    end

    // Walk from the farthest candidate back to ptr+1 so the nearest set request wins.
    always_comb begin
        win_valid_next = 1'b0;
        win_idx_next   = '0;
        cand           = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(ptr_reg) + k) % NUM_REQ;
            if (req[cand]) begin
                win_valid_next = 1'b1;
                win_idx_next   = IDX_W'(cand);
            end
        end
    end

    function automatic logic [7:0] pick_byte(input logic [1:0] idx, input logic [6:0] dev,
                                             input logic [7:0] ra, input logic [7:0] wd);
        case (idx)
            2'd0:    pick_byte = {dev, 1'b0};
            2'd1:    pick_byte = ra;
            default: pick_byte = wd;
        endcase
    endfunction

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_reg;

    assign to_hit = ((state_reg == WAIT_BUSY) || (state_reg == WAIT_DONE)) &&
                    (to_cnt_reg == 16'(TIMEOUT_CYC - 1));

    // Restart on entry to each wait state; the FSM leaves on the cycle the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ISSUE || (state_reg == WAIT_BUSY && m_busy)) begin
            to_cnt_reg <= '0;
        end else if (state_reg == WAIT_BUSY || state_reg == WAIT_DONE) begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign m_rw = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= IDX_W'(NUM_REQ - 1);
            winner_reg    <= '0;
            byte_idx_reg  <= '0;
            nack_flag_reg <= 1'b0;
            dev_reg       <= '0;
            reg_addr_reg  <= '0;
            data_reg      <= '0;
            grant         <= '0;
            done          <= '0;
            nack          <= 1'b0;
            timeout       <= 1'b0;
            m_start       <= 1'b0;
            m_data        <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid_next) begin
                        grant         <= NUM_REQ'(1) << win_idx_next;
                        winner_reg    <= win_idx_next;
                        dev_reg       <= dev_arr[win_idx_next];
                        reg_addr_reg  <= reg_arr[win_idx_next];
                        data_reg      <= data_arr[win_idx_next];
                        byte_idx_reg  <= 2'd0;
                        nack_flag_reg <= 1'b0;
                        m_start       <= 1'b1;
                        m_data        <= {dev_arr[win_idx_next], 1'b0};
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start   <= 1'b0;
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (to_hit) begin
                        done      <= NUM_REQ'(1) << winner_reg;
                        nack      <= nack_flag_reg;
                        timeout   <= 1'b1;
                        state_reg <= FINISH;
                    end else if (m_busy) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (to_hit) begin
                        done      <= NUM_REQ'(1) << winner_reg;
                        nack      <= nack_flag_reg;
                        timeout   <= 1'b1;
                        state_reg <= FINISH;
                    end else if (m_busy) begin
                        // ack_error is dropped by the engine as busy falls, so only sample while busy.
                        nack_flag_reg <= nack_flag_reg | m_ack_error;
                    end else if (nack_flag_reg || byte_idx_reg == 2'd2) begin
                        done      <= NUM_REQ'(1) << winner_reg;
                        nack      <= nack_flag_reg;
                        timeout   <= 1'b0;
                        state_reg <= FINISH;
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        m_start      <= 1'b1;
                        m_data       <= pick_byte(byte_idx_reg + 2'd1, dev_reg, reg_addr_reg, data_reg);
                        state_reg    <= ISSUE;
                    end
                end
                FINISH: begin
                    done      <= '0;
                    nack      <= 1'b0;
                    timeout   <= 1'b0;
                    grant     <= '0;
                    ptr_reg   <= winner_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Scoreboard bench for i2c_write_arbiter with a small behavioural i2c engine model.
module tb_i2c_write_arbiter;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 65535;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_dev;
    logic [8*NUM_REQ-1:0] req_reg;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 nack;
    logic                 timeout;
    logic                 m_start;
    logic                 m_rw;
    logic [7:0]           m_data;
    logic                 m_busy;
    logic                 m_ack_error;

    i2c_write_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_dev(req_dev), .req_reg(req_reg),
        .req_data(req_data), .grant(grant), .done(done), .nack(nack), .timeout(timeout),
        .m_start(m_start), .m_rw(m_rw), .m_data(m_data), .m_busy(m_busy),
        .m_ack_error(m_ack_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int idx;
        bit nck;
        bit tmo;
        int nbytes;
    } done_exp_t;

    logic [7:0] exp_bytes[$];
    done_exp_t  exp_done[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts_seen = 0;

    logic [6:0] devs  [NUM_REQ];
    logic [7:0] regs  [NUM_REQ];
    logic [7:0] datas [NUM_REQ];

    int eng_nack_byte = -1;
    bit eng_dead      = 1'b0;
    int eng_bytes     = 0;
    int busy_left     = 0;
    int wait_left     = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy rises a cycle after start, lasts 5 cycles; ack_error drops with busy.
    initial begin
        m_busy = 1'b0;
        m_ack_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_busy = 1'b0; m_ack_error = 1'b0;
                busy_left = 0; wait_left = 0; eng_bytes = 0;
            end else begin
                if (m_busy) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        m_busy = 1'b0; m_ack_error = 1'b0;
                    end else if (busy_left == 2 && eng_nack_byte == eng_bytes - 1) begin
                        m_ack_error = 1'b1;
                    end
                end else if (wait_left > 0) begin
                    wait_left--;
                    if (wait_left == 0) begin
                        m_busy = 1'b1; busy_left = 5;
                    end
                end
                if (m_start) begin
                    eng_bytes++;
                    if (!eng_dead) wait_left = 1;
                end
                if (done != 0) eng_bytes = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each m_start and each done pulse.
    initial begin
        done_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                starts_seen = 0;
            end else begin
                check_val("grant_onehot", 32'($onehot0(grant)), 1);
                if (m_start) begin
                    starts_seen++;
                    check_val("m_rw", m_rw, 0);
                    check_val("byte_expected", 32'(exp_bytes.size() != 0), 1);
                    if (exp_bytes.size() != 0) check_val("m_data", m_data, exp_bytes.pop_front());
                    if (exp_done.size() != 0) check_val("grant_owner", grant, 1 << exp_done[0].idx);
                end
                if (done != 0) begin
                    $display("txn done=%b nack=%0d timeout=%0d starts=%0d", done, nack, timeout, starts_seen);
                    check_val("done_expected", 32'(exp_done.size() != 0), 1);
                    if (exp_done.size() != 0) begin
                        e = exp_done.pop_front();
                        check_val("done_idx", done, 1 << e.idx);
                        check_val("nack", nack, e.nck);
                        check_val("timeout", timeout, e.tmo);
                        check_val("start_count", starts_seen, e.nbytes);
                    end
                    starts_seen = 0;
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
        devs[i] = d; regs[i] = r; datas[i] = v;
        req_dev[i*7 +: 7]  = d;
        req_reg[i*8 +: 8]  = r;
        req_data[i*8 +: 8] = v;
    endtask

    task automatic push_txn(input int i, input int nbytes, input bit nck, input bit tmo);
        done_exp_t e;
        logic [7:0] b [3];
        b[0] = {devs[i], 1'b0}; b[1] = regs[i]; b[2] = datas[i];
        for (int k = 0; k < nbytes; k++) exp_bytes.push_back(b[k]);
        e.idx = i; e.nck = nck; e.tmo = tmo; e.nbytes = nbytes;
        exp_done.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 0 && n < budget);
        check_val("done_within_budget", 32'(done != 0), 1);
    endtask

    task automatic wait_byte_busy(input int nb, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(eng_bytes == nb && m_busy) && n < budget);
        check_val("engine_busy_reached", 32'(eng_bytes == nb && m_busy), 1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        exp_bytes.delete();
        exp_done.delete();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_issue;
        rst_n = 1'b0;
        req = '0;
        req_dev = '0; req_reg = '0; req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, 7'h20 + 7'(i), 8'h30 + 8'(i), 8'h40 + 8'(i));
        repeat (3) @(negedge clk);
        check_val("rst_grant", grant, 0);
        check_val("rst_done", done, 0);
        check_val("rst_nack", nack, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_m_start", m_start, 0);
        check_val("rst_m_rw", m_rw, 0);
        check_val("rst_m_data", m_data, 8'h00);
        #1 rst_n = 1'b1;

        // Basic write from requester 1
        set_ops(1, 7'h50, 8'h10, 8'hA5);
        push_txn(1, 3, 1'b0, 1'b0);
        @(negedge clk);
        req[1] = 1'b1;
        wait_done(200);
        req[1] = 1'b0;

        // Round robin: 0,2 then all four -> 3,0,1,2
        reset_dut();
        set_ops(1, 7'h21, 8'h31, 8'h41);
        push_txn(0, 3, 1'b0, 1'b0);
        push_txn(2, 3, 1'b0, 1'b0);
        req = 4'b0101;
        wait_done(200);
        wait_done(200);
        push_txn(3, 3, 1'b0, 1'b0);
        push_txn(0, 3, 1'b0, 1'b0);
        push_txn(1, 3, 1'b0, 1'b0);
        push_txn(2, 3, 1'b0, 1'b0);
        req = 4'b1111;
        repeat (3) wait_done(200);
        wait_done(200);
        req = '0;

        // NACK on byte0 aborts the rest
        eng_nack_byte = 0;
        push_txn(2, 1, 1'b1, 1'b0);
        req[2] = 1'b1;
        wait_done(200);
        req[2] = 1'b0;
        eng_nack_byte = -1;
        repeat (8) @(negedge clk);
        check_val("no_extra_bytes", exp_bytes.size(), 0);

        // Reset during byte1, then restart from byte0
        reset_dut();
        set_ops(0, 7'h50, 8'h10, 8'hA5);
        push_txn(0, 3, 1'b0, 1'b0);
        req[0] = 1'b1;
        wait_byte_busy(2, 200);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_grant", grant, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_m_start", m_start, 0);
        check_val("mid_rst_m_data", m_data, 8'h00);
        check_val("mid_rst_bytes_left", exp_bytes.size(), 1);
        repeat (2) @(negedge clk);
        exp_bytes.delete();
        exp_done.delete();
        push_txn(0, 3, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        wait_done(200);
        req[0] = 1'b0;

        // Requester 3 drops req during byte1; write still completes
        set_ops(3, 7'h2A, 8'h55, 8'hC3);
        push_txn(3, 3, 1'b0, 1'b0);
        @(negedge clk);
        req[3] = 1'b1;
        wait_byte_busy(2, 200);
        req[3] = 1'b0;
        wait_done(200);

`ifdef I2C_ARB_TIMEOUT_EN
        // Engine never goes busy: watchdog finishes the transaction
        eng_dead = 1'b1;
        push_txn(1, 1, 1'b0, 1'b1);
        @(negedge clk);
        req[1] = 1'b1;
        t_issue = -1;
        for (int n = 0; n < 50 && !m_start; n++) @(negedge clk);
        t_issue = cyc;
        wait_done(100);
        check_val("timeout_latency", cyc - t_issue, 17);
        req[1] = 1'b0;
        eng_dead = 1'b0;
`else
        t_issue = 0;
`endif

        repeat (5) @(negedge clk);
        check_val("scoreboard_bytes_empty", exp_bytes.size(), 0);
        check_val("scoreboard_done_empty", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
